pipeline_hazard_sequencer: RTL
==============================

// Module: pipeline_hazard_sequencer
// PURPOSE
//  Parametrised next-generation hazard control for the N-stage mips_core pipeline.
//  Converts per-stage hold requests, early/late PC redirects and active-list recovery
//  into per-register stall/flush and load_pc controls. Adds pending-redirect buffering,
//  a recovery/drain FSM and a fetch-starvation watchdog.
// PARAMETERS
//  NUM_STAGES   6    pipeline registers; reg 0 = PC, reg i feeds stage i
//  ADDR_WIDTH   32   PC width
//  EARLY_STAGE  1    stage issuing predicted-taken/jump redirects (decode)
//  LATE_STAGE   4    stage issuing mispredict recovery redirects (execute); > EARLY_STAGE
//  ISSUE_STAGE  2    youngest stage squashed/held by active-list recovery
//  DRAIN_CYCLES 2    bubble cycles after recovery completes (>=1)
//  WDOG_LIMIT   1023 consecutive reg-0 stall cycles before timeout
// PORTS
//  clk            in  1           clock
//  rst_n          in  1           synchronous reset, active low
//  hold_req       in  NUM_STAGES  stage k cannot accept/advance this cycle (icache miss, lw, dcache miss)
//  early_valid    in  1           early redirect request
//  early_target   in  ADDR_WIDTH  early redirect PC
//  late_valid     in  1           late (mispredict) redirect request
//  late_target    in  ADDR_WIDTH  recovery PC
//  recover_req    in  1           active-list flush start (pulse)
//  recover_done   in  1           active-list flush complete (pulse)
//  recover_pc     in  ADDR_WIDTH  restart PC, valid with recover_done
//  stall          out NUM_STAGES  pipeline register i holds
//  flush          out NUM_STAGES  pipeline register i loads bubble; flush[0] always 0
//  load_pc_we     out 1           PC register overload
//  load_pc_new_pc out ADDR_WIDTH  overload value
//  recovering     out 1           FSM not in RUN
//  wdog_timeout   out 1           sticky; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FSM=RUN, pending cleared, drain/wdog counters 0,
//   wdog_timeout=0. Combinational outputs then: stall=0, flush=0, load_pc_we=0,
//   new_pc=0, recovering=0.
//  Base (RUN): stall[i] = OR(hold_req[k], k>=i); flush[i] = hold_req[i-1] & ~stall[i].
//   Downstream stall always dominates.
//  Redirect apply at stage r, possible only when stall[r+1]=0 (or r=N-1):
//   load_pc_we=1; flush[1..r]=1; stall[0..r]=0. Overrides hold_req[0..r].
//  Simultaneous: late beats early; early dropped. Same cycle as recover_req: redirects dropped.
//  Pending: redirect that cannot apply is latched (1 entry: target + source).
//   Applies the first cycle its stage is unblocked, even if the input dropped.
//   New late replaces pending early. Pending late ignores new early.
//   New late while late pending overwrites it.
//  FSM RUN->RECOVER on recover_req; pending cleared.
//  RECOVER: stall[0..ISSUE_STAGE]=1; flush[ISSUE_STAGE+1]=1 unless stalled;
//   regs above ISSUE_STAGE per base rules; redirects dropped.
//  RECOVER->DRAIN on recover_done:
//   that cycle load_pc_we=1, new_pc=recover_pc, flush[1..ISSUE_STAGE]=1, stall[0]=0.
//  DRAIN: flush[1..ISSUE_STAGE]=1 for DRAIN_CYCLES cycles incl. entry, then RUN.
//   Redirects dropped. recover_req in DRAIN restarts RECOVER.
//  recover_done in RUN: ignored. recover_req in RECOVER: ignored.
//  Watchdog: counter++ while stall[0]=1, else 0; saturates at WDOG_LIMIT.
//   wdog_timeout=1 the cycle after reaching WDOG_LIMIT.
//  Reset mid-recovery or with a pending redirect: state discarded, no PC load.
// TESTING
//  hold_req=6'b010000 -> stall=6'b011111, flush=6'b100000; release -> 0/0.
//  early_valid, target 0x400 -> load_pc_we=1, new_pc=0x400, flush=6'b000010.
//   late 0x800 same cycle -> new_pc=0x800, flush=6'b011110.
//  hold_req[5]=1 3 cycles with late 0x900 pulsed cycle 0 -> no load; cycle 3: load 0x900, flush[1..4]=1.
//  recover_req; 5 cycles; recover_done pc 0x1000 -> recovering=1 for 5 cycles, stall[0..2]=1;
//   then load 0x1000, flush[1..2]=1 two cycles; early redirect meanwhile dropped.
//  hold_req[0]=1 for 1023 cycles -> wdog_timeout=1 next cycle; stays after release.
//  rst_n=0 during DRAIN -> next cycle all outputs 0, recovering=0.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeline_hazard_sequencer                                        |
// | Purpose  : Hazard control for an N-stage in-order pipeline. Turns per-stage |
// |            hold requests, early/late PC redirects and active-list recovery  |
// |            into per-register stall/flush and PC overload controls. Holds    |
// |            one pending redirect, runs a RUN/RECOVER/DRAIN sequencer and a   |
// |            fetch-starvation watchdog.                                       |
// | Ports    : clk, rst_n (sync, active low)                                    |
// |            hold_req_i[N]      per-stage hold requests                       |
// |            early_valid_i/early_target_i  decode-stage redirect              |
// |            late_valid_i/late_target_i    execute-stage recovery redirect    |
// |            recover_req_i/recover_done_i/recover_pc_i  active-list recovery  |
// |            stall_o[N], flush_o[N]         pipeline register controls        |
// |            load_pc_we_o/load_pc_new_pc_o  PC register overload              |
// |            recovering_o, wdog_timeout_o   status                            |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipeline_hazard_sequencer #(
  parameter int NUM_STAGES   = 6,
  parameter int ADDR_WIDTH   = 32,
  parameter int EARLY_STAGE  = 1,
  parameter int LATE_STAGE   = 4,
  parameter int ISSUE_STAGE  = 2,
  parameter int DRAIN_CYCLES = 2,
  parameter int WDOG_LIMIT   = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_STAGES-1:0] hold_req_i,
  input  logic                  early_valid_i,
  input  logic [ADDR_WIDTH-1:0] early_target_i,
  input  logic                  late_valid_i,
  input  logic [ADDR_WIDTH-1:0] late_target_i,
  input  logic                  recover_req_i,
  input  logic                  recover_done_i,
  input  logic [ADDR_WIDTH-1:0] recover_pc_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  load_pc_we_o,
  output logic [ADDR_WIDTH-1:0] load_pc_new_pc_o,
  output logic                  recovering_o,
  output logic                  wdog_timeout_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int WDOG_W  = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    pend_late_q, pend_late_d;
  logic [ADDR_WIDTH-1:0]   pend_target_q, pend_target_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic                    wdog_timeout_q, wdog_timeout_d;

  logic [NUM_STAGES-1:0]   base_stall, base_flush, hold_masked;
  logic                    req_valid, req_late, req_free;
  logic [ADDR_WIDTH-1:0]   req_target;
  int                      req_stage;

  // A register holds whenever it or anything downstream of it holds.
  function automatic logic [NUM_STAGES-1:0] hold_to_stall(input logic [NUM_STAGES-1:0] h);
    logic [NUM_STAGES-1:0] s;
    s = '0;
    s[NUM_STAGES-1] = h[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) s[i] = h[i] | s[i+1];
    return s;
  endfunction

  // A stage that holds while its consumer advances must hand over a bubble.
  function automatic logic [NUM_STAGES-1:0] hold_to_flush(input logic [NUM_STAGES-1:0] h,
                                                          input logic [NUM_STAGES-1:0] s);
    logic [NUM_STAGES-1:0] f;
    f = '0;
    for (int i = 1; i < NUM_STAGES; i++) f[i] = h[i-1] & ~s[i];
    return f;
  endfunction

  assign base_stall = hold_to_stall(hold_req_i);
  assign base_flush = hold_to_flush(hold_req_i, base_stall);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pend_valid_q   <= 1'b0;
      pend_late_q    <= 1'b0;
      pend_target_q  <= '0;
      drain_q        <= '0;
      wdog_q         <= '0;
      wdog_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_late_q    <= pend_late_d;
      pend_target_q  <= pend_target_d;
      drain_q        <= drain_d;
      wdog_q         <= wdog_d;
      wdog_timeout_q <= wdog_timeout_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pend_valid_d     = pend_valid_q;
    pend_late_d      = pend_late_q;
    pend_target_d    = pend_target_q;
    drain_d          = drain_q;
    stall_o          = base_stall;
    flush_o          = base_flush;
    load_pc_we_o     = 1'b0;
    load_pc_new_pc_o = '0;
    req_valid        = 1'b0;
    req_late         = 1'b0;
    req_target       = '0;
    req_stage        = EARLY_STAGE;
    req_free         = 1'b0;
    hold_masked      = hold_req_i;

    case (state_q)
      ST_RUN: begin
        if (recover_req_i) begin
          // Recovery supersedes any redirect, pending or new.
          state_d      = ST_RECOVER;
          pend_valid_d = 1'b0;
        end else begin
          // A new late redirect always wins; a pending entry shadows new early ones.
          if (late_valid_i) begin
            req_valid  = 1'b1;
            req_late   = 1'b1;
            req_target = late_target_i;
          end else if (pend_valid_q) begin
            req_valid  = 1'b1;
            req_late   = pend_late_q;
            req_target = pend_target_q;
          end else if (early_valid_i) begin
            req_valid  = 1'b1;
            req_late   = 1'b0;
            req_target = early_target_i;
          end
          req_stage = req_late ? LATE_STAGE : EARLY_STAGE;
          // The redirecting instruction must be able to leave its stage.
          req_free = 1'b1;
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (i == req_stage + 1 && base_stall[i]) req_free = 1'b0;
          end
          if (req_valid && req_free) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (i <= req_stage) hold_masked[i] = 1'b0;
            end
            stall_o = hold_to_stall(hold_masked);
            flush_o = hold_to_flush(hold_masked, stall_o);
            for (int i = 1; i < NUM_STAGES; i++) begin
              if (i <= req_stage) flush_o[i] = 1'b1;
            end
            load_pc_we_o     = 1'b1;
            load_pc_new_pc_o = req_target;
            pend_valid_d     = 1'b0;
          end else if (req_valid) begin
            pend_valid_d  = 1'b1;
            pend_late_d   = req_late;
            pend_target_d = req_target;
          end
        end
      end

      ST_RECOVER: begin
        // Front end frozen; the first register past issue drains as bubbles.
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i <= ISSUE_STAGE) begin
            stall_o[i] = 1'b1;
            flush_o[i] = 1'b0;
          end else if (i == ISSUE_STAGE + 1) begin
            flush_o[i] = ~base_stall[i];
          end
        end
        if (recover_done_i) begin
          load_pc_we_o     = 1'b1;
          load_pc_new_pc_o = recover_pc_i;
          stall_o[0]       = 1'b0;
          for (int i = 1; i < NUM_STAGES; i++) begin
            if (i <= ISSUE_STAGE) flush_o[i] = 1'b1;
          end
          // This cycle is the first bubble cycle of the drain window.
          if (DRAIN_CYCLES > 1) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_DRAIN: begin
        for (int i = 1; i < NUM_STAGES; i++) begin
          if (i <= ISSUE_STAGE) flush_o[i] = 1'b1;
        end
        if (recover_req_i) begin
          state_d = ST_RECOVER;
        end else if (drain_q <= DRAIN_W'(1)) begin
          state_d = ST_RUN;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end

      default: state_d = ST_RUN;
    endcase

    recovering_o = (state_q != ST_RUN);

    if (stall_o[0]) begin
      wdog_d = (wdog_q == WDOG_W'(WDOG_LIMIT)) ? wdog_q : wdog_q + WDOG_W'(1);
    end else begin
      wdog_d = '0;
    end
    wdog_timeout_d = wdog_timeout_q | (wdog_d == WDOG_W'(WDOG_LIMIT));
  end

  assign wdog_timeout_o = wdog_timeout_q;

endmodule
`default_nettype wire
